// File: rtl/up_down_counter_pkg.sv
// up_down_counter_pkg
//   Shared constants and types for the loadable up/down counter.
//   COUNTER_WIDTH : default counter/data width in bits
//   MODE_UP       : direction select value for counting up
//   MODE_DOWN     : direction select value for counting down
//   count_t       : counter value type at the default width
package up_down_counter_pkg;

  localparam int COUNTER_WIDTH = 8;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  typedef logic [COUNTER_WIDTH-1:0] count_t;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_next.sv
// up_down_counter_next
//   Combinational step computation for the up/down counter: given the
//   current count and direction, produce the value one step away.
//   Build option UP_DOWN_COUNTER_SATURATE_EN:
//     undefined - modulo 2^WIDTH wrap-around in both directions
//     defined   - up-count holds at all-ones, down-count holds at zero
//   Ports:
//     count (in,  WIDTH) current register value
//     mode  (in,  1)     0 = up, 1 = down
//     step  (out, WIDTH) next value if the counter steps this edge
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             mode,
  output logic [WIDTH-1:0] step
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifdef UP_DOWN_COUNTER_SATURATE_EN
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - CNT_ONE;
  endfunction
`else
  // Plain WIDTH-bit add/subtract drops the carry/borrow, giving modulo wrap.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    return v + CNT_ONE;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    return v - CNT_ONE;
  endfunction
`endif

  always_comb begin
    step = step_up(count);
    if (mode == MODE_DOWN) begin
      step = step_down(count);
    end
  end

endmodule : up_down_counter_next

// File: rtl/up_down_counter.sv
// up_down_counter
//   Loadable synchronous up/down counter. Each rising clk edge applies
//   exactly one action, highest priority first: clear, load, step.
//   There is no hold state; the counter steps whenever clr and ld are low.
//   Build option UP_DOWN_COUNTER_SATURATE_EN selects saturating instead of
//   wrapping steps (see up_down_counter_next); clear/load are unaffected.
//   Ports:
//     clk   (in,  1)     rising-edge clock
//     clr   (in,  1)     synchronous active-high clear, highest priority
//     din   (in,  WIDTH) parallel load value
//     ld    (in,  1)     synchronous load enable
//     mode  (in,  1)     0 = count up, 1 = count down
//     count (out, WIDTH) counter register, driven directly
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] step_val;

  up_down_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count (count_q),
    .mode  (mode),
    .step  (step_val)
  );

  // Load beats step; clear is applied in the register itself.
  always_comb begin
    count_d = step_val;
    if (ld) begin
      count_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
module tb_up_down_counter;

  logic       clk;
  logic       clr;
  logic [7:0] din;
  logic       ld;
  logic       mode;
  logic [7:0] count;

  int passed;
  int total;

  up_down_counter #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .din   (din),
    .ld    (ld),
    .mode  (mode),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    total++;
    assert (count === exp) passed++;
    else $error("FAIL %s: count=%0d expected=%0d", tag, count, exp);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    clr    = 1'b1;
    ld     = 1'b0;
    din    = 8'd0;
    mode   = 1'b0;

    // Clear from unknown state
    tick();
    chk("reset", 8'd0);

    // Clear beats load
    ld  = 1'b1;
    din = 8'd10;
    tick();
    chk("clr_over_ld", 8'd0);

    // Load 10
    clr = 1'b0;
    tick();
    chk("load10", 8'd10);

    // Count up 11..15
    ld   = 1'b0;
    mode = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("up", 8'(10 + i));
    end

    // Switch direction: 14 down to 0
    mode = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      tick();
      chk("down", 8'(i));
    end

    // Down past zero
    tick();
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    chk("down_wrap", 8'd0);
`else
    chk("down_wrap", 8'd255);
`endif

    // Load 255 and count up past the top
    ld   = 1'b1;
    din  = 8'd255;
    mode = 1'b0;
    tick();
    chk("load255", 8'd255);
    ld = 1'b0;
    tick();
`ifdef UP_DOWN_COUNTER_SATURATE_EN
    chk("up_wrap", 8'd255);
    tick();
    chk("up_wrap2", 8'd255);
`else
    chk("up_wrap", 8'd0);
    tick();
    chk("up_wrap2", 8'd1);
`endif

    // Load beats step
    ld   = 1'b1;
    din  = 8'd200;
    mode = 1'b1;
    tick();
    chk("ld_over_mode", 8'd200);
    ld  = 1'b0;
    din = 8'd77;
    tick();
    chk("after_load", 8'd199);
    tick();
    chk("din_ignored", 8'd198);

    // Clear mid-count
    ld  = 1'b1;
    din = 8'd100;
    tick();
    chk("load100", 8'd100);
    ld = 1'b0;
    tick();
    chk("dn99", 8'd99);
    tick();
    chk("dn98", 8'd98);
    clr = 1'b1;
    tick();
    chk("clr_mid", 8'd0);
    clr  = 1'b0;
    mode = 1'b0;
    tick();
    chk("up1", 8'd1);
    tick();
    chk("up2", 8'd2);
    tick();
    chk("up3", 8'd3);

    // Per-cycle direction toggling
    mode = 1'b1;
    tick();
    chk("toggle_dn", 8'd2);
    mode = 1'b0;
    tick();
    chk("toggle_up", 8'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_up_down_counter
